// File: rtl/ram_bus_master.sv
// ram_bus_master: single-word initiator for the processor RAM sysbus protocol.
// Arbitrates for the sysbus, then sequences the MAR/MDR/CS strobes for one read or write.
// Optional feature: define WRITE_VERIFY_EN to read back and compare every write.
module ram_bus_master #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned OP_W   = 3,
    localparam int unsigned ADDR_W = WORD_W - OP_W
) (
    input  logic              i_clock,
    input  logic              i_n_reset,
    input  logic              i_req,
    input  logic              i_rnw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_err,
    output logic [WORD_W-1:0] o_rdata,
    output logic              o_bus_req,
    input  logic              i_bus_gnt,
    output logic              o_load_MAR,
    output logic              o_load_MDR,
    output logic              o_CS,
    output logic              o_R_NW,
    output logic              o_MDR_bus,
    inout  wire  [WORD_W-1:0] io_sysbus
);

    typedef enum logic [3:0] {
        StIdle,
        StArb,
        StMar,
        StLdw,
        StWr,
        StRd,
        StXfer,
`ifdef WRITE_VERIFY_EN
        StCmp,
`endif
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic                r_rnw;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic                r_err;
    logic [WORD_W-1:0]   r_rdata;
    logic                w_drive;
    logic [WORD_W-1:0]   w_bus_out;

    // State register
    always_ff @(posedge i_clock or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic; losing the grant in any bus-driving state aborts to DONE
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (i_req) w_state_d = StArb;
            StArb:   if (i_bus_gnt) w_state_d = StMar;
            StMar: begin
                if (!i_bus_gnt || !r_addr[ADDR_W-1]) w_state_d = StDone;
                else if (r_rnw)                      w_state_d = StRd;
                else                                 w_state_d = StLdw;
            end
            StLdw:   w_state_d = i_bus_gnt ? StWr : StDone;
`ifdef WRITE_VERIFY_EN
            StWr:    w_state_d = i_bus_gnt ? StRd : StDone;
`else
            StWr:    w_state_d = StDone;
`endif
            StRd:    w_state_d = i_bus_gnt ? StXfer : StDone;
`ifdef WRITE_VERIFY_EN
            StXfer:  w_state_d = (!i_bus_gnt || r_rnw) ? StDone : StCmp;
            StCmp:   w_state_d = StDone;
`else
            StXfer:  w_state_d = StDone;
`endif
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Request latch, status and read-data registers
    always_ff @(posedge i_clock or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_rnw   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_req) begin
                        r_rnw   <= i_rnw;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        r_err   <= 1'b0;
                    end
                end
                // Only the top half of the address space is backed by RAM
                StMar: if (!i_bus_gnt || !r_addr[ADDR_W-1]) r_err <= 1'b1;
                StLdw, StWr, StRd: if (!i_bus_gnt) r_err <= 1'b1;
                StXfer: begin
                    if (i_bus_gnt) r_rdata <= io_sysbus;
                    else           r_err   <= 1'b1;
                end
`ifdef WRITE_VERIFY_EN
                StCmp: if (r_rdata != r_wdata) r_err <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Moore output decode; strobes and bus drive are gated by the grant so an abort is instant
    always_comb begin
        o_ready    = (r_state == StIdle);
        o_done     = (r_state == StDone);
        o_bus_req  = (r_state != StIdle);
        o_load_MAR = (r_state == StMar) && i_bus_gnt;
        o_load_MDR = (r_state == StLdw) && i_bus_gnt;
        o_CS       = ((r_state == StWr) || (r_state == StRd)) && i_bus_gnt;
        o_R_NW     = (r_state == StRd) && i_bus_gnt;
        o_MDR_bus  = (r_state == StXfer) && i_bus_gnt;
        w_drive    = 1'b0;
        w_bus_out  = '0;
        if (i_bus_gnt) begin
            if (r_state == StMar) begin
                w_drive   = 1'b1;
                w_bus_out = {{OP_W{1'b0}}, r_addr};
            end else if (r_state == StLdw) begin
                w_drive   = 1'b1;
                w_bus_out = r_wdata;
            end
        end
    end

    assign o_err     = r_err;
    assign o_rdata   = r_rdata;
    assign io_sysbus = w_drive ? w_bus_out : {WORD_W{1'bz}};

endmodule
